// File: rtl/mult_control.sv
// Sequencing control for the 8-bit shift-add signed multiplier.
// Steps START -> (ADD, SHIFT) x N_BITS -> HOLD and drives the datapath strobes.
module mult_control #(
  parameter int N_BITS  = 8,
  parameter int COUNT_W = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Run,
  input  logic               ClearA_LoadB,
  input  logic               M,
  output logic               Clr_Ld,
  output logic               Clear_XA,
  output logic               Add,
  output logic               Sub,
  output logic               Shift_En,
  output logic               Busy,
  output logic               Done,
  output logic [COUNT_W-1:0] Count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  localparam logic [COUNT_W-1:0] LAST_CNT = COUNT_W'(N_BITS - 1);

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;

  // State and iteration counter registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        count_d = '0;
        if (Run) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        count_d = '0;
        state_d = S_ADD;
      end
      S_ADD: begin
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (count_q == LAST_CNT) begin
          state_d = S_HOLD;
        end else begin
          count_d = count_q + COUNT_W'(1);
          state_d = S_ADD;
        end
      end
      S_HOLD: begin
        if (Run) begin
          state_d = S_HOLD;
        end else begin
          state_d = S_IDLE;
          count_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
  end

  // Datapath strobes; the final iteration subtracts to correct for the sign bit
  always_comb begin
    Clr_Ld   = 1'b0;
    Clear_XA = 1'b0;
    Add      = 1'b0;
    Sub      = 1'b0;
    Shift_En = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        Clr_Ld = ClearA_LoadB & ~Run;
      end
      S_START: begin
        Clear_XA = 1'b1;
        Busy     = 1'b1;
      end
      S_ADD: begin
        Busy = 1'b1;
        if (M) begin
          if (count_q == LAST_CNT) begin
            Sub = 1'b1;
          end else begin
            Add = 1'b1;
          end
        end else begin
          Add = 1'b0;
          Sub = 1'b0;
        end
      end
      S_SHIFT: begin
        Shift_En = 1'b1;
        Busy     = 1'b1;
      end
      S_HOLD: begin
        Done = 1'b1;
      end
      default: begin
        Busy = 1'b0;
      end
    endcase
  end

  assign Count = count_q;

endmodule

// File: doc/mult_control.md
Name: mult_control

Overview:
- Sequencing control unit for the 8-bit shift-add signed multiplier datapath.
- Sits directly upstream of the A and B 8-bit shift registers and the X sign flip-flop.
- Drives their load, clear and shift-enable lines and the 9-bit adder's add/subtract selects.
- Performs one start-to-done multiply per Run press, using the multiplier LSB (B register Shift_Out) to decide add/subtract per iteration.

Parameters:
- N_BITS, 8, number of multiply iterations (operand width).
- COUNT_W, 4, iteration counter width; must satisfy 2^COUNT_W > N_BITS.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Run  input  1  start request, level (debounced button, active-high).
- ClearA_LoadB  input  1  idle-time request to load B from switches and clear A/X.
- M  input  1  current multiplier LSB (B register Shift_Out).
- Clr_Ld  output  1  load B from switches, clear A and X.
- Clear_XA  output  1  clear A and X at start of a multiply.
- Add  output  1  adder result (A + S) to be loaded into X:A.
- Sub  output  1  adder result (A - S) to be loaded into X:A.
- Shift_En  output  1  shift X->A->B right by one.
- Busy  output  1  multiply in progress.
- Done  output  1  result valid in A:B, waiting for Run release.
- Count  output  COUNT_W  iteration index, for debug/visibility.

Behaviour:
- States: IDLE, START, ADD, SHIFT, HOLD; state and Count are registered.
- Reset has priority over everything: next edge goes to IDLE with Count=0.
  - All outputs are 0 in IDLE when ClearA_LoadB=0.
  - Reset mid-operation aborts immediately; no further Add/Sub/Shift_En pulses.
- IDLE:
  - Run=1 -> START.
  - Otherwise Clr_Ld = ClearA_LoadB, combinational, idle only.
  - Run and ClearA_LoadB both high -> Run wins; Clr_Ld=0.
- START: one cycle; Clear_XA=1, Busy=1, Count<=0; -> ADD.
- ADD: one cycle; Busy=1.
  - M=1 and Count<N_BITS-1 -> Add=1.
  - M=1 and Count==N_BITS-1 -> Sub=1 (sign correction on final iteration).
  - M=0 -> neither.
  - Add and Sub are never high together.
  - -> SHIFT.
- SHIFT: one cycle; Shift_En=1, Busy=1.
  - Count<N_BITS-1 -> Count<=Count+1, -> ADD.
  - Count==N_BITS-1 -> Count held, -> HOLD.
- HOLD: Done=1, Busy=0.
  - Remains while Run=1; Run=0 -> IDLE with Count<=0.
  - Always occupied at least one cycle, even if Run already dropped.
- Run deassertion during START/ADD/SHIFT is ignored; the multiply always completes.
- ClearA_LoadB is ignored outside IDLE.
- Timing: Run sampled high at edge 0 in IDLE gives:
  - START in cycle 1.
  - ADD_i in cycle 2+2i, SHIFT_i in cycle 3+2i (i = 0..N_BITS-1).
  - Last SHIFT in cycle 2*N_BITS+1 (17 for N_BITS=8).
  - HOLD from cycle 2*N_BITS+2.
- Busy high exactly 2*N_BITS+1 cycles; exactly N_BITS Shift_En pulses per multiply.
- M is sampled only in ADD; its value in other states has no effect.
- Count never wraps: stays in 0..N_BITS-1.

Test Plan:
- Reset held 2 cycles, then released with Run=0, ClearA_LoadB=0:
  - All outputs 0, Count=0, for 5 cycles.
- Idle load:
  - ClearA_LoadB=1, Run=0 -> Clr_Ld=1 same cycle.
  - ClearA_LoadB=1, Run=1 in IDLE -> Clr_Ld=0, START next cycle.
- M driven per B=0x07 (M=1,1,1,0,0,0,0,0 across ADD_0..ADD_7), Run pulsed high 1 cycle:
  - Clear_XA in cycle 1.
  - Add in cycles 2, 4, 6; no Sub.
  - Shift_En in cycles 3, 5, ..., 17 (8 pulses).
  - Busy cycles 1-17; Done from cycle 18 for exactly 1 cycle, then IDLE.
- M per B=0x81 (M=1 at ADD_0 and ADD_7), Run held high 25 cycles:
  - Add in cycle 2, Sub in cycle 16.
  - Done held high cycles 18-25; IDLE one cycle after Run drops.
  - Second Run press repeats the identical sequence.
- Reset asserted in cycle 9 (SHIFT_3) of a multiply:
  - IDLE next cycle, Count=0.
  - No Add/Sub/Shift_En afterwards.
  - A new Run restarts at START.
- Run toggled low/high during ADD/SHIFT:
  - Sequence unchanged.
  - Exactly one START per multiply; no restart before HOLD->IDLE.
